fetch_unit: RTL

Parametrised instruction-fetch stage replacing the free-running word counter of the single-cycle RV32 core. Holds a byte-addressed PC and fetches from an instruction memory over a request/acknowledge handshake with variable latency. Presents one instruction at a time to decode/execute with a valid/stall handshake. Applies branch/jump redirects (PCSel, aluOut), flags misaligned targets and counts retired instructions.

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_unit_next_pc.sv | 23 ++
 rtl/fetch_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// reset instruction and the sequential PC step.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_VALID = 2'd3
    } fetch_state_e;

    // addi x0, x0, 0 -- presented before the first real fetch lands
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int unsigned PC_INC = 4;

    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Next-PC selection: sequential step or redirect target forced to a word
// boundary, plus the link value and a flag for an unaligned target.
module fetch_next_pc
    import fetch_unit_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic            pc_sel_i,
    input  logic [PC_W-1:0] target_i,
    output logic [PC_W-1:0] next_pc_o,
    output logic [PC_W-1:0] pc_plus4_o,
    output logic            misaligned_o
);

    localparam logic [PC_W-1:0] STEP = PC_W'(PC_INC);

    assign pc_plus4_o   = pc_i + STEP;
    // Unaligned redirects still fetch, just from the word containing the target
    assign next_pc_o    = pc_sel_i ? {target_i[PC_W-1:2], 2'b00} : pc_plus4_o;
    assign misaligned_o = pc_sel_i && !is_word_aligned(target_i[1:0]);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: byte PC, one outstanding request to instruction
// memory, valid/stall handoff to decode, redirect handling and instret.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter int              XLEN     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            sysCLK,
    input  logic            nRST,
    output logic            imemReq,
    output logic [PC_W-1:0] imemAddr,
    input  logic            imemAck,
    input  logic [XLEN-1:0] imemData,
    output logic [XLEN-1:0] instr32,
    output logic [PC_W-1:0] PC,
    output logic [PC_W-1:0] PCNext,
    output logic            instValid,
    input  logic            stall,
    input  logic            PCSel,
    input  logic [XLEN-1:0] aluOut,
    output logic            misalignErr,
    output logic [XLEN-1:0] instret
);

    if (PC_W < 3) begin : g_bad_pc_w
        $error("fetch_unit: PC_W must be at least 3");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("fetch_unit: RESET_PC must be word aligned");
    end

    fetch_state_e    state_q;
    logic [PC_W-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic            valid_q;
    logic            misalign_q;
    logic [XLEN-1:0] instret_q;

    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_plus4;
    logic            target_misaligned;
    logic            consume;

    fetch_next_pc #(
        .PC_W (PC_W)
    ) u_next_pc (
        .pc_i         (pc_q),
        .pc_sel_i     (PCSel),
        .target_i     (aluOut[PC_W-1:0]),
        .next_pc_o    (pc_d),
        .pc_plus4_o   (pc_plus4),
        .misaligned_o (target_misaligned)
    );

    if (XLEN > PC_W) begin : g_alu_hi
        logic unused_alu_hi;
        assign unused_alu_hi = ^aluOut[XLEN-1:PC_W];
    end

    assign consume = (state_q == ST_VALID) && !stall;

    // The follow-on request leaves in the consume cycle itself so a one-cycle
    // memory sustains one instruction every two cycles.
    assign imemReq  = (state_q == ST_ISSUE) || consume;
    assign imemAddr = consume ? pc_d : pc_q;

    always_ff @(posedge sysCLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= XLEN'(NOP_INSTR);
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            instret_q  <= '0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (imemAck) begin
                        instr_q <= imemData;
                        valid_q <= 1'b1;
                        state_q <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (consume) begin
                        pc_q       <= pc_d;
                        valid_q    <= 1'b0;
                        misalign_q <= target_misaligned;
                        instret_q  <= instret_q + XLEN'(1);
                        state_q    <= ST_WAIT;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign instr32     = instr_q;
    assign PC          = pc_q;
    assign PCNext      = pc_plus4;
    assign instValid   = valid_q;
    assign misalignErr = misalign_q;
    assign instret     = instret_q;

endmodule
